// File: rtl/clock_pkg.sv
// Shared types for the pixel-clock lock qualifier and reset sequencer.
package clock_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } lock_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/clock_lock_ctrl.sv
// PLL lock qualifier and downstream reset sequencer in the pixel-clock domain.
// Optional macro CLOCK_LOCK_COUNT_EN: implements the saturating loss_count (else tied to 0).
module clock_lock_ctrl
  import clock_pkg::*;
#(
  parameter int NUM_LOCKS     = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_HOLD      = 16,
  parameter int LOSS_W        = 8
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic [NUM_LOCKS-1:0] pll_locked,
  output logic              clk_pix_locked,
  output logic              rst_out,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int CNT_MAX = max_int(STABLE_CYCLES, RST_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("clock_lock_ctrl: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
      $error("clock_lock_ctrl: STABLE_CYCLES must be >= 1");
    end
    if (RST_HOLD < 1) begin : g_bad_rst_hold
      $error("clock_lock_ctrl: RST_HOLD must be >= 1");
    end
  endgenerate

  logic [NUM_LOCKS-1:0] lock_sync;
  logic                 lock_s;

  sync_bits #(
    .WIDTH (NUM_LOCKS),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk_pix),
    .rst(rst),
    .d  (pll_locked),
    .q  (lock_sync)
  );

  // A partial lock is no lock at all.
  assign lock_s = &lock_sync;

  lock_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             locked_reg;
  logic             rst_out_reg;
  logic             lost_reg;
  logic             lost_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      WAIT: begin
        cnt_next = '0;
        if (lock_s) begin
          state_next = QUAL;
        end
      end
      QUAL: begin
        if (!lock_s) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == QUAL_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Only a drop after qualification counts as a loss; QUAL drops are glitches.
  assign lost_next = ((state_reg == HOLD) || (state_reg == RUN)) && !lock_s;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_reg   <= WAIT;
      cnt_reg     <= '0;
      locked_reg  <= 1'b0;
      rst_out_reg <= 1'b1;
      lost_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      locked_reg  <= (state_next == HOLD) || (state_next == RUN);
      rst_out_reg <= (state_next != RUN);
      lost_reg    <= lost_next;
    end
  end

  assign clk_pix_locked = locked_reg;
  assign rst_out        = rst_out_reg;
  assign lock_lost      = lost_reg;

`ifdef CLOCK_LOCK_COUNT_EN
  logic [LOSS_W-1:0] loss_count_reg;

  // Counts on the same edge that raises lock_lost, so both appear together.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      loss_count_reg <= '0;
    end else if (lost_next && (loss_count_reg != {LOSS_W{1'b1}})) begin
      loss_count_reg <= loss_count_reg + 1'b1;
    end
  end

  assign loss_count = loss_count_reg;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_clock_lock_ctrl.sv
// Randomised and directed bench for clock_lock_ctrl using a lock-streak reference model.
module tb_clock_lock_ctrl;

  localparam int NL = 2;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int RH = 4;
  localparam int LW = 2;
  localparam int CNT_SAT = (1 << LW) - 1;

  logic          clk_pix = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] pll_locked = '0;
  logic          clk_pix_locked;
  logic          rst_out;
  logic          lock_lost;
  logic [LW-1:0] loss_count;

  always #5 clk_pix = ~clk_pix;

  clock_lock_ctrl #(
    .NUM_LOCKS    (NL),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .RST_HOLD     (RH),
    .LOSS_W       (LW)
  ) dut (
    .clk_pix       (clk_pix),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clk_pix_locked(clk_pix_locked),
    .rst_out       (rst_out),
    .lock_lost     (lock_lost),
    .loss_count    (loss_count)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: ANDed lock seen by the controller is the input from SS edges earlier;
  // the state follows from how many consecutive edges that lock has been high.
  bit hist[SS];
  int streak;
  int losses;
  bit m_locked, m_rst, m_lost;

  function automatic int exp_count();
`ifdef CLOCK_LOCK_COUNT_EN
    return (losses > CNT_SAT) ? CNT_SAT : losses;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d act=%0d exp=%0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    streak   = 0;
    losses   = 0;
    m_locked = 1'b0;
    m_rst    = 1'b1;
    m_lost   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("clk_pix_locked", 32'(clk_pix_locked), 32'(m_locked));
    chk("rst_out", 32'(rst_out), 32'(m_rst));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("loss_count", 32'(loss_count), 32'(exp_count()));
    $display("edge %0d pll=%b locked=%b rst_out=%b lost=%b count=%0d",
             edge_n, pll_locked, clk_pix_locked, rst_out, lock_lost, loss_count);
  endtask

  task automatic step(input logic [NL-1:0] p);
    bit ls;
    pll_locked = p;
    @(posedge clk_pix);
    edge_n++;
    ls = hist[SS-1];
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = &p;
    m_lost = 1'b0;
    if (ls) begin
      if (streak < SC + RH + 1) streak++;
    end else begin
      if (streak >= SC + 1) begin
        m_lost = 1'b1;
        losses++;
      end
      streak = 0;
    end
    m_locked = (streak >= SC + 1);
    m_rst    = (streak < SC + RH + 1);
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges and checks the outputs react without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_locked", 32'(clk_pix_locked), 32'd0);
    chk("rst_rst_out", 32'(rst_out), 32'd1);
    chk("rst_lost", 32'(lock_lost), 32'd0);
    chk("rst_count", 32'(loss_count), 32'd0);
    @(negedge clk_pix);
    rst = 1'b0;
  endtask

  // Drives full lock from WAIT and measures rise/fall latency from the first high edge.
  task automatic lock_and_measure(input int n, output int rise, output int fall, output bit any_lost);
    int k;
    k = edge_n + 1;
    rise = -1;
    fall = -1;
    any_lost = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(2'b11);
      if (clk_pix_locked && rise < 0) rise = edge_n - k;
      if (!rst_out && fall < 0) fall = edge_n - k;
      if (lock_lost) any_lost = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d act=timeout exp=finish", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise, fall, k;
    bit any_lost, any_rst_low;
    logic [NL-1:0] p;

    model_reset();
    repeat (2) @(posedge clk_pix);
    #1;
    chk("init_locked", 32'(clk_pix_locked), 32'd0);
    chk("init_rst_out", 32'(rst_out), 32'd1);
    chk("init_lost", 32'(lock_lost), 32'd0);
    chk("init_count", 32'(loss_count), 32'd0);
    @(negedge clk_pix);
    rst = 1'b0;

    // Clean lock from WAIT.
    repeat (3) step(2'b00);
    lock_and_measure(20, rise, fall, any_lost);
    chk("clean_lock_latency", 32'(rise), 32'd10);
    chk("clean_rst_latency", 32'(fall), 32'd14);
    chk("clean_no_lost", 32'(any_lost), 32'd0);

    // Loss in RUN: bit0 drops at edge m.
    step(2'b10);
    step(2'b10);
    chk("run_loss_not_yet", 32'(lock_lost), 32'd0);
    step(2'b10);
    chk("run_loss_pulse", 32'(lock_lost), 32'd1);
    chk("run_loss_locked", 32'(clk_pix_locked), 32'd0);
    chk("run_loss_rst_out", 32'(rst_out), 32'd1);
`ifdef CLOCK_LOCK_COUNT_EN
    chk("run_loss_count", 32'(loss_count), 32'd1);
`else
    chk("run_loss_count", 32'(loss_count), 32'd0);
`endif
    step(2'b00);
    chk("run_loss_one_cycle", 32'(lock_lost), 32'd0);
    step(2'b00);
    lock_and_measure(20, rise, fall, any_lost);
    chk("relock_latency", 32'(rise), 32'd10);
    chk("relock_rst_latency", 32'(fall), 32'd14);
    repeat (4) step(2'b00);

    // Glitch in QUAL: bit1 low for one edge at k+5.
    k = edge_n + 1;
    rise = -1;
    any_lost = 1'b0;
    for (int i = 0; i < 25; i++) begin
      p = (i == 5) ? 2'b01 : 2'b11;
      step(p);
      if (clk_pix_locked && rise < 0) rise = edge_n - k;
      if (lock_lost) any_lost = 1'b1;
    end
    chk("glitch_lock_latency", 32'(rise), 32'd16);
    chk("glitch_no_lost", 32'(any_lost), 32'd0);
    repeat (4) step(2'b00);

    // Loss in HOLD: drop two cycles after the lock indication rises.
    rise = -1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      step(2'b11);
      if (clk_pix_locked) rise = i;
    end
    chk("hold_reached", 32'(rise >= 0), 32'd1);
    any_rst_low = !rst_out;
    any_lost = 1'b0;
    step(2'b11);
    for (int i = 0; i < 6; i++) begin
      step(2'b00);
      if (!rst_out) any_rst_low = 1'b1;
      if (lock_lost) any_lost = 1'b1;
    end
    chk("hold_loss_pulse", 32'(any_lost), 32'd1);
    chk("hold_rst_never_low", 32'(any_rst_low), 32'd0);

    // Randomised lock patterns with long and short runs.
    for (int blk = 0; blk < 60; blk++) begin
      int len;
      len = int'($urandom_range(1, 20));
      p = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, 2)) : 2'b11;
      repeat (len) step(p);
    end

    // Saturation: five qualified losses from a fresh reset.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      repeat (16) step(2'b11);
      repeat (4) step(2'b00);
    end
`ifdef CLOCK_LOCK_COUNT_EN
    chk("sat_count", 32'(loss_count), 32'd3);
`else
    chk("sat_count", 32'(loss_count), 32'd0);
`endif

    // Reset asserted while running.
    repeat (16) step(2'b11);
    chk("pre_reset_run", 32'(rst_out), 32'd0);
    do_reset();
    repeat (4) step(2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
